// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel processor: per-thread run states and
// the default thread count reused by the PC bank and register file.
package barrel_pkg;

  localparam int NUM_THREADS_DEFAULT = 8;

  localparam int TS_W = 2;
  localparam logic [TS_W-1:0] TS_OFF  = 2'd0;
  localparam logic [TS_W-1:0] TS_RUN  = 2'd1;
  localparam logic [TS_W-1:0] TS_WAIT = 2'd2;

  // The unused encoding collapses to OFF so a corrupted entry can never issue.
  function automatic logic [TS_W-1:0] ts_norm(input logic [TS_W-1:0] s);
    return (s == TS_RUN || s == TS_WAIT) ? s : TS_OFF;
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Pipeline-facing bundle of the thread scheduler: lifecycle events in,
// issue slot and run status out.
interface thread_scheduler_if
  import barrel_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT
);

  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  logic                    stall;
  logic                    start_valid;
  logic [BITS_THREADS-1:0] start_tid;
  logic                    halt_valid;
  logic [BITS_THREADS-1:0] halt_tid;
  logic                    block_valid;
  logic [BITS_THREADS-1:0] block_tid;
  logic                    wake_valid;
  logic [BITS_THREADS-1:0] wake_tid;
  logic                    issue_valid;
  logic [BITS_THREADS-1:0] tid;
  logic [NUM_THREADS-1:0]  run_mask;
  logic                    all_off;

  modport master (
    output stall, start_valid, start_tid, halt_valid, halt_tid,
           block_valid, block_tid, wake_valid, wake_tid,
    input  issue_valid, tid, run_mask, all_off
  );

  modport slave (
    input  stall, start_valid, start_tid, halt_valid, halt_tid,
           block_valid, block_tid, wake_valid, wake_tid,
    output issue_valid, tid, run_mask, all_off
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set bit of elig after ptr,
// wrapping around, so ptr itself is considered last.
module rr_pick #(
  parameter int NUM_THREADS = 8,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  elig,
  input  logic [BITS_THREADS-1:0] ptr,
  output logic                    any,
  output logic [BITS_THREADS-1:0] next
);

  logic [BITS_THREADS-1:0]  base;
  logic [2*NUM_THREADS-1:0] window;

  // Shifting the doubled vector puts thread ptr+1 at bit 0; the lowest set
  // bit of the low half is the winner, offset back by base.
  always_comb begin
    base   = ptr + BITS_THREADS'(1);
    window = {elig, elig} >> base;
    any    = |elig;
    next   = ptr;
    for (int j = NUM_THREADS - 1; j >= 0; j--) begin
      if (window[j]) begin
        next = base + BITS_THREADS'(j);
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-processor issue controller: tracks OFF/RUN/WAIT per thread and
// issues runnable threads round-robin to the PC bank select.
module thread_scheduler
  import barrel_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT,
  parameter logic [NUM_THREADS-1:0] RESET_RUN_MASK = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
  input logic               clk,
  input logic               rst,
  thread_scheduler_if.slave bus
);

  localparam int BITS_THREADS = $clog2(NUM_THREADS);
  typedef logic [BITS_THREADS-1:0] tid_t;

  if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_param
    $error("thread_scheduler: NUM_THREADS must be a power of two >= 2");
  end

  logic [TS_W-1:0] state_q [NUM_THREADS];
  logic [TS_W-1:0] state_d [NUM_THREADS];

  logic [NUM_THREADS-1:0] halt_hit;
  logic [NUM_THREADS-1:0] block_hit;
  logic [NUM_THREADS-1:0] wake_hit;
  logic [NUM_THREADS-1:0] start_hit;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] run_next;
  logic [NUM_THREADS-1:0] off_now;

  logic                   issue_valid_q;
  tid_t                   tid_q;
  tid_t                   rr_ptr_q;
  logic [NUM_THREADS-1:0] run_mask_q;
  logic                   pick_any;
  tid_t                   pick_next;

  always_comb begin
    halt_hit  = bus.halt_valid  ? (NUM_THREADS'(1) << bus.halt_tid)  : '0;
    block_hit = bus.block_valid ? (NUM_THREADS'(1) << bus.block_tid) : '0;
    wake_hit  = bus.wake_valid  ? (NUM_THREADS'(1) << bus.wake_tid)  : '0;
    start_hit = bus.start_valid ? (NUM_THREADS'(1) << bus.start_tid) : '0;
  end

  // The highest-priority event aimed at a thread claims it outright, even
  // when that event is not legal from the current state.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = ts_norm(state_q[i]);
      if (halt_hit[i]) begin
        state_d[i] = TS_OFF;
      end else if (block_hit[i]) begin
        if (ts_norm(state_q[i]) == TS_RUN) state_d[i] = TS_WAIT;
      end else if (wake_hit[i]) begin
        if (ts_norm(state_q[i]) == TS_WAIT) state_d[i] = TS_RUN;
      end else if (start_hit[i]) begin
        if (ts_norm(state_q[i]) == TS_OFF) state_d[i] = TS_RUN;
      end
      elig[i]     = (ts_norm(state_q[i]) == TS_RUN) && !halt_hit[i] && !block_hit[i];
      run_next[i] = (state_d[i] == TS_RUN);
      off_now[i]  = (ts_norm(state_q[i]) == TS_OFF);
    end
  end

  rr_pick #(
    .NUM_THREADS(NUM_THREADS)
  ) u_rr_pick (
    .elig(elig),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .next(pick_next)
  );

  // Reset leaves the pointer on the last thread so thread 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= RESET_RUN_MASK[i] ? TS_RUN : TS_OFF;
      end
      issue_valid_q <= 1'b0;
      tid_q         <= '0;
      rr_ptr_q      <= tid_t'(NUM_THREADS - 1);
      run_mask_q    <= RESET_RUN_MASK;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= state_d[i];
      end
      run_mask_q <= run_next;
      if (!bus.stall && pick_any) begin
        issue_valid_q <= 1'b1;
        tid_q         <= pick_next;
        rr_ptr_q      <= pick_next;
      end else begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.tid         = tid_q;
  assign bus.run_mask    = run_mask_q;
  assign bus.all_off     = &off_now;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench: directed lifecycle scenarios followed by random
// events, compared every cycle against a queue-free array model.
module tb_thread_scheduler;

  localparam int N = 8;
  localparam logic [7:0] RESET_MASK = 8'h01;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Model: state per thread (0 off, 1 run, 2 wait) plus the expected
  // registered outputs after the edge currently being driven.
  int ms [N];
  int mptr;
  int mtid;
  bit mvalid;
  bit modelReady = 1'b0;

  thread_scheduler_if #(.NUM_THREADS(N)) bus ();

  thread_scheduler #(
    .NUM_THREADS   (N),
    .RESET_RUN_MASK(RESET_MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: condition not reached within bound at %0t", name, $time);
  endtask

  task automatic checkOutput();
    int em;
    int eo;
    if (!modelReady) return;
    em = 0;
    eo = 1;
    for (int i = 0; i < N; i++) begin
      if (ms[i] == 1) em = em | (1 << i);
      if (ms[i] != 0) eo = 0;
    end
    cmp("issue_valid", int'(bus.issue_valid), int'(mvalid));
    cmp("tid", int'(bus.tid), mtid);
    cmp("run_mask", int'(bus.run_mask), em);
    cmp("all_off", int'(bus.all_off), eo);
  endtask

  task automatic modelStep(input bit r, input bit stl,
                           input bit sv, input int st, input bit hv, input int ht,
                           input bit bv, input int bt, input bit wv, input int wt);
    int pick;
    if (r) begin
      for (int i = 0; i < N; i++) ms[i] = RESET_MASK[i] ? 1 : 0;
      mvalid = 1'b0;
      mtid   = 0;
      mptr   = N - 1;
      return;
    end
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (pick < 0 && ms[c] == 1 && !(hv && ht == c) && !(bv && bt == c)) pick = c;
    end
    if (!stl && pick >= 0) begin
      mvalid = 1'b1;
      mtid   = pick;
      mptr   = pick;
    end else begin
      mvalid = 1'b0;
    end
    for (int t = 0; t < N; t++) begin
      if (hv && ht == t) ms[t] = 0;
      else if (bv && bt == t) begin if (ms[t] == 1) ms[t] = 2; end
      else if (wv && wt == t) begin if (ms[t] == 2) ms[t] = 1; end
      else if (sv && st == t) begin if (ms[t] == 0) ms[t] = 1; end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit stl,
                               input bit sv, input int st, input bit hv, input int ht,
                               input bit bv, input int bt, input bit wv, input int wt);
    @(negedge clk);
    checkOutput();
    rst             = r;
    bus.stall       = stl;
    bus.start_valid = sv;
    bus.start_tid   = 3'(st);
    bus.halt_valid  = hv;
    bus.halt_tid    = 3'(ht);
    bus.block_valid = bv;
    bus.block_tid   = 3'(bt);
    bus.wake_valid  = wv;
    bus.wake_tid    = 3'(wt);
    modelStep(r, stl, sv, st, hv, ht, bv, bt, wv, wt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idleUntilTid(input int t, input string name);
    int k;
    k = 0;
    while (!(mvalid && mtid == t) && k < 16) begin
      idle(1);
      k++;
    end
    if (k == 16) timeoutFail(name);
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_tid   = '0;
    bus.halt_valid  = 1'b0;
    bus.halt_tid    = '0;
    bus.block_valid = 1'b0;
    bus.block_tid   = '0;
    bus.wake_valid  = 1'b0;
    bus.wake_tid    = '0;
    modelStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReady = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    cmp("reset_issue_valid", int'(bus.issue_valid), 1);
    cmp("reset_tid", int'(bus.tid), 0);
    cmp("reset_run_mask", int'(bus.run_mask), 'h01);
    cmp("reset_all_off", int'(bus.all_off), 0);

    for (int t = 1; t < N; t++) applyStimulus(0, 0, 1, t, 0, 0, 0, 0, 0, 0);
    idle(11);
    cmp("all_started_mask", int'(bus.run_mask), 'hFF);

    // Block thread 3 on the very edge that would have issued it.
    idleUntilTid(2, "wait_tid2");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(1);
    cmp("block_skip_tid", int'(bus.tid), 4);
    cmp("block_mask", int'(bus.run_mask), 'hF7);
    idle(9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    idle(10);
    cmp("wake_mask", int'(bus.run_mask), 'hFF);

    applyStimulus(0, 0, 0, 0, 1, 5, 1, 5, 1, 5);
    idle(1);
    cmp("multi_event_mask", int'(bus.run_mask), 'hDF);
    applyStimulus(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    idle(1);
    cmp("start_on_run_mask", int'(bus.run_mask), 'hDF);
    applyStimulus(0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    idle(2);

    idleUntilTid(6, "wait_tid6");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cmp("stall_valid", int'(bus.issue_valid), 0);
    cmp("stall_tid", int'(bus.tid), 6);
    idle(1);
    cmp("release_valid", int'(bus.issue_valid), 1);
    cmp("release_tid", int'(bus.tid), 7);

    for (int t = 0; t < N; t++) applyStimulus(0, 0, 0, 0, 1, t, 0, 0, 0, 0);
    idle(1);
    cmp("halt_all_off", int'(bus.all_off), 1);
    cmp("halt_all_valid", int'(bus.issue_valid), 0);

    // Park threads in WAIT, then reset while other events are in flight.
    applyStimulus(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    applyStimulus(1, 0, 1, 3, 0, 0, 0, 0, 1, 2);
    idle(1);
    cmp("midreset_mask", int'(bus.run_mask), 'h01);
    cmp("midreset_valid", int'(bus.issue_valid), 0);
    idle(1);
    cmp("midreset_first_valid", int'(bus.issue_valid), 1);
    cmp("midreset_first_tid", int'(bus.tid), 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 0, int'($urandom_range(0, N - 1)),
                    $urandom_range(0, 7) == 0, int'($urandom_range(0, N - 1)),
                    $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)),
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, N - 1)));
    end
    idle(1);
    @(negedge clk);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
